dma_channel_arbiter: RTL and testbench
======================================

// Module: dma_channel_arbiter
// PURPOSE
//  Parametrised DREQ arbiter for the DMA controller. Qualifies NCH DREQ lines against polarity,
//  mask and software requests, then selects a channel by fixed or rotating priority.
//  Runs the HRQ/HLDA hold handshake with the CPU and drives the per-channel DACK lines.
//  Sits between the pins/register file and the timing-control FSM, which consumes grant_ch.
// PARAMETERS
//  NCH  4  number of DMA channels (2..16); CW = $clog2(NCH) is a localparam
// PORTS
//  CLK         in   1    system clock, all state on rising edge
//  RESET       in   1    asynchronous, active-high reset
//  DREQ        in   NCH  channel request pins (polarity per dreq_low)
//  sw_req      in   NCH  software request bits from the request register
//  mask        in   NCH  1 = channel masked, its hardware and software requests ignored
//  ctrl_dis    in   1    controller disable (command bit 2); blocks new arbitration
//  rotating    in   1    1 = rotating priority, 0 = fixed (ch0 highest)
//  dreq_low    in   1    1 = DREQ active-low
//  dack_low    in   1    1 = DACK active-low
//  HLDA        in   1    hold acknowledge from CPU
//  xfer_done   in   1    one-cycle pulse from timing control: service of granted channel ended
//  HRQ         out  1    hold request to CPU
//  DACK        out  NCH  channel acknowledge pins (polarity per dack_low)
//  grant_valid out  1    1 while a channel is in SERVICE
//  grant_ch    out  CW   index of the locked winner
// BEHAVIOUR
//  - Qualify: req_q <= ((DREQ ^ {NCH{dreq_low}}) | sw_req) & ~mask, registered (1 cycle).
//  - Arbitration: winner = first set bit of req_q scanning upward from ptr, modulo NCH.
//    Fixed mode uses ptr = 0. Winner is locked into grant_ch on the IDLE->WAIT_HLDA transition.
//  - FSM states IDLE, WAIT_HLDA, SERVICE, RELEASE:
//    IDLE:      if !ctrl_dis && |req_q && !HLDA -> lock winner, HRQ<=1, go WAIT_HLDA.
//    WAIT_HLDA: if req_q[grant_ch] drops -> HRQ<=0, go IDLE (re-arbitrate).
//               else if HLDA -> dack_oh<=onehot(grant_ch), grant_valid<=1, go SERVICE.
//    SERVICE:   xfer_done -> dack_oh<=0, grant_valid<=0, HRQ<=0, go RELEASE.
//               If rotating, ptr <= (grant_ch+1) mod NCH.
//               If HLDA falls without xfer_done (abort) -> same outputs, no rotation, go IDLE.
//    RELEASE:   wait for HLDA==0, then go IDLE.
//  - Latency: DREQ edge -> HRQ = 2 CLK. HLDA -> DACK = 1 CLK. xfer_done -> DACK/HRQ inactive = 1 CLK.
//  - DACK = dack_oh ^ {NCH{dack_low}} (combinational from registered dack_oh); at most one DACK active.
//  - ptr is CW bits, wraps NCH-1 -> 0 (non-power-of-2 NCH must wrap explicitly).
//    ptr forced to 0 whenever rotating==0.
//  - Locked winner is never pre-empted by a higher-priority request during WAIT_HLDA/SERVICE.
//  - mask is ignored for the locked channel once in SERVICE. Mask changes affect req_q only.
//  - ctrl_dis does not abort an in-progress handshake; it only blocks leaving IDLE.
//  - Reset (any state, async): state=IDLE, HRQ=0, dack_oh=0 (DACK at inactive level),
//    grant_valid=0, grant_ch=0, ptr=0, req_q=0.
// CONFIGURATION
//  DMA_ARB_DREQ_SYNC_EN defined: DREQ passes a 2-flop synchronizer before qualification.
//    DREQ->HRQ latency becomes 4 CLK; synchronizer flops reset to the inactive level (dreq_low).
//  Undefined: DREQ is sampled directly into req_q (2 CLK latency). All other behaviour identical.
// TESTING
//  1 NCH=4, fixed, DREQ=4'b1010 active-high -> HRQ at +2 CLK; HLDA=1 -> DACK=4'b0010 next CLK, grant_ch=1.
//  2 Rotating, ch1 served then xfer_done -> ptr=2; DREQ=4'b0011 held -> next grant ch0 (wraps); then ch1.
//  3 dreq_low=1, dack_low=1, DREQ=4'b1110 -> ch0 requested; DACK=4'b1110 in SERVICE, 4'b1111 otherwise.
//  4 mask=4'b0001, sw_req=4'b0001, DREQ=0 -> no HRQ; clear mask -> HRQ 2 CLK later, grant ch0.
//  5 Drop winner's DREQ in WAIT_HLDA -> HRQ=0 next CLK. HLDA fall in SERVICE -> DACK inactive, ptr unchanged.
//  6 RESET asserted mid-SERVICE -> HRQ=0, DACK inactive, grant_valid=0 immediately (no CLK edge).
//    NCH=3 rotating wrap check: grant ch2 -> ptr=0.

Source files
------------

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: qualifies NCH DREQ lines against polarity, mask and
// software requests, then picks a channel by fixed or rotating priority.
// It runs the HRQ/HLDA hold handshake and drives the per-channel DACK pins.
// Optional feature macro: DMA_ARB_DREQ_SYNC_EN adds a 2-flop DREQ synchronizer.
module dma_channel_arbiter #(
  parameter int NCH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NCH-1:0]         i_dreq,
  input  logic [NCH-1:0]         i_swReq,
  input  logic [NCH-1:0]         i_mask,
  input  logic                   i_ctrlDis,
  input  logic                   i_rotating,
  input  logic                   i_dreqLow,
  input  logic                   i_dackLow,
  input  logic                   i_hlda,
  input  logic                   i_xferDone,
  output logic                   o_hrq,
  output logic [NCH-1:0]         o_dack,
  output logic                   o_grantValid,
  output logic [$clog2(NCH)-1:0] o_grantCh
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_HLDA,
    S_SERVICE,
    S_RELEASE
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [NCH-1:0]  w_dreqAct;
  logic [NCH-1:0]  r_reqQ;
  logic [CW-1:0]   r_ptr;
  logic [CW-1:0]   r_grantCh;
  logic [CW-1:0]   w_scanPtr;
  logic [CW-1:0]   w_winner;
  logic            w_hrq;
  logic            w_grantValid;
  logic [NCH-1:0]  w_dackOh;

  // Reduce any integer to a channel index; NCH need not be a power of two.
  function automatic logic [CW-1:0] wrapIndex(input int v);
    return CW'(v % NCH);
  endfunction

`ifdef DMA_ARB_DREQ_SYNC_EN
  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;

  // Two-flop synchronizer holding DREQ already normalised to active-high, so reset to 0 is the inactive level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_dreq ^ {NCH{i_dreqLow}};
      r_sync2 <= r_sync1;
    end
  end

  assign w_dreqAct = r_sync2;
`else
  assign w_dreqAct = i_dreq ^ {NCH{i_dreqLow}};
`endif

  // Register the qualified request vector; mask blocks both pin and software requests.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_reqQ <= '0;
    end else begin
      r_reqQ <= (w_dreqAct | i_swReq) & ~i_mask;
    end
  end

  // Pick the first requesting channel scanning upward from the priority pointer.
  always_comb begin
    w_scanPtr = i_rotating ? r_ptr : '0;
    w_winner  = w_scanPtr;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (r_reqQ[wrapIndex(int'(w_scanPtr) + k)]) begin
        w_winner = wrapIndex(int'(w_scanPtr) + k);
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic for the hold handshake.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (!i_ctrlDis && (|r_reqQ) && !i_hlda) begin
          w_nextState = S_WAIT_HLDA;
        end
      end
      S_WAIT_HLDA: begin
        if (!r_reqQ[r_grantCh]) begin
          w_nextState = S_IDLE;
        end else if (i_hlda) begin
          w_nextState = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (i_xferDone) begin
          w_nextState = S_RELEASE;
        end else if (!i_hlda) begin
          w_nextState = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (!i_hlda) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Handshake outputs follow the state directly, so reset clears them without a clock edge.
  always_comb begin
    w_hrq        = (r_state == S_WAIT_HLDA) || (r_state == S_SERVICE);
    w_grantValid = (r_state == S_SERVICE);
    w_dackOh     = '0;
    if (r_state == S_SERVICE) begin
      w_dackOh[r_grantCh] = 1'b1;
    end
  end

  // Lock the winner only when leaving IDLE so it cannot be pre-empted later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_grantCh <= '0;
    end else if ((r_state == S_IDLE) && (w_nextState == S_WAIT_HLDA)) begin
      r_grantCh <= w_winner;
    end
  end

  // Rotate priority past the channel just completed; aborts leave the pointer alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (!i_rotating) begin
      r_ptr <= '0;
    end else if ((r_state == S_SERVICE) && i_xferDone) begin
      r_ptr <= wrapIndex(int'(r_grantCh) + 1);
    end
  end

  assign o_hrq        = w_hrq;
  assign o_grantValid = w_grantValid;
  assign o_grantCh    = r_grantCh;
  assign o_dack       = w_dackOh ^ {NCH{i_dackLow}};

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb_dma_channel_arbiter: directed and randomized checks of dma_channel_arbiter
// against a cycle-level behavioural model of the hold handshake and priority rules.
module tb_dma_channel_arbiter;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_SERV = 2;
  localparam int P_REL  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dreq, swReq, mask;
  logic       ctrlDis, rotating, dreqLow, dackLow, hlda, xferDone;
  logic       hrq, grantValid;
  logic [3:0] dack;
  logic [1:0] grantCh;

  logic [2:0] dreq3;
  logic       hlda3, xferDone3;
  logic       hrq3, grantValid3;
  logic [2:0] dack3;
  logic [1:0] grantCh3;

  int testsRun = 0;
  int testsFailed = 0;

  logic [3:0] mReq;
  int         mPhase, mGrant, mPtr;

  always #5 clk = ~clk;

  dma_channel_arbiter #(.NCH(4)) u4 (
    .i_clk(clk), .i_rst(rst), .i_dreq(dreq), .i_swReq(swReq), .i_mask(mask),
    .i_ctrlDis(ctrlDis), .i_rotating(rotating), .i_dreqLow(dreqLow), .i_dackLow(dackLow),
    .i_hlda(hlda), .i_xferDone(xferDone), .o_hrq(hrq), .o_dack(dack),
    .o_grantValid(grantValid), .o_grantCh(grantCh)
  );

  dma_channel_arbiter #(.NCH(3)) u3 (
    .i_clk(clk), .i_rst(rst), .i_dreq(dreq3), .i_swReq(3'b000), .i_mask(3'b000),
    .i_ctrlDis(1'b0), .i_rotating(1'b1), .i_dreqLow(1'b0), .i_dackLow(1'b0),
    .i_hlda(hlda3), .i_xferDone(xferDone3), .o_hrq(hrq3), .o_dack(dack3),
    .o_grantValid(grantValid3), .o_grantCh(grantCh3)
  );

  // Single comparison point: counts the check and reports any disagreement.
  task automatic expectEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // First requesting channel counting upward from start, wrapping at 4.
  function automatic int pickWinner(input logic [3:0] req, input int start);
    for (int k = 0; k < 4; k++) begin
      if (req[2'((start + k) % 4)]) return (start + k) % 4;
    end
    return 0;
  endfunction

  task automatic modelReset();
    mReq   = 4'b0000;
    mPhase = P_IDLE;
    mGrant = 0;
    mPtr   = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic modelStep();
    logic [3:0] newReq;
    newReq = ((dreq ^ {4{dreqLow}}) | swReq) & ~mask;
    if (rst) begin
      modelReset();
      return;
    end
    case (mPhase)
      P_IDLE: if (!ctrlDis && mReq != 4'b0000 && !hlda) begin
        mGrant = pickWinner(mReq, rotating ? mPtr : 0);
        mPhase = P_WAIT;
      end
      P_WAIT: if (!mReq[2'(mGrant)]) mPhase = P_IDLE;
              else if (hlda) mPhase = P_SERV;
      P_SERV: if (xferDone) begin
        mPhase = P_REL;
        if (rotating) mPtr = (mGrant + 1) % 4;
      end else if (!hlda) begin
        mPhase = P_IDLE;
      end
      default: if (!hlda) mPhase = P_IDLE;
    endcase
    if (!rotating) mPtr = 0;
    mReq = newReq;
  endtask

  task automatic checkOutput();
    logic       expHrq;
    logic [3:0] expDack;
    expHrq  = (mPhase == P_WAIT) || (mPhase == P_SERV);
    expDack = ((mPhase == P_SERV) ? (4'b0001 << mGrant) : 4'b0000) ^ {4{dackLow}};
    expectEq("hrq", 32'(hrq), 32'(expHrq));
    expectEq("dack", 32'(dack), 32'(expDack));
    expectEq("grant_valid", 32'(grantValid), 32'(mPhase == P_SERV));
    expectEq("grant_ch", 32'(grantCh), 32'(mGrant));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  // Complete a service on the 4-channel unit from WAIT_HLDA; leaves it in RELEASE with HLDA low.
  task automatic serve(input logic [3:0] expDack);
    hlda = 1'b1;
    tick();
    expectEq("dack_service", 32'(dack), 32'(expDack));
    xferDone = 1'b1;
    tick();
    xferDone = 1'b0;
    hlda = 1'b0;
  endtask

  // Complete a service on the 3-channel unit and present the next request vector.
  task automatic serve3(input logic [2:0] expDack, input logic [2:0] nextReq);
    hlda3 = 1'b1;
    tick();
    expectEq("nch3_dack", 32'(dack3), 32'(expDack));
    xferDone3 = 1'b1;
    tick();
    xferDone3 = 1'b0;
    hlda3 = 1'b0;
    dreq3 = nextReq;
    tick();
  endtask

  // Randomized cycle: the CPU side reacts to the model's handshake phase.
  task automatic applyStimulus();
    rst   = ($urandom_range(0, 199) == 0);
    if ($urandom_range(0, 2) == 0) dreq = 4'($urandom);
    swReq = 4'($urandom & $urandom & $urandom);
    mask  = 4'($urandom & $urandom);
    ctrlDis = ($urandom_range(0, 9) == 0);
    if ($urandom_range(0, 49) == 0) rotating = ~rotating;
    if ($urandom_range(0, 79) == 0) dreqLow = ~dreqLow;
    if ($urandom_range(0, 39) == 0) dackLow = ~dackLow;
    xferDone = ($urandom_range(0, 29) == 0);
    case (mPhase)
      P_IDLE:  hlda = ($urandom_range(0, 7) == 0);
      P_WAIT:  hlda = ($urandom_range(0, 2) != 0);
      P_SERV: begin
        hlda = ($urandom_range(0, 19) != 0);
        xferDone = ($urandom_range(0, 3) == 0);
      end
      default: hlda = ($urandom_range(0, 2) == 0);
    endcase
    tick();
  endtask

  initial begin
    rst = 1'b1;
    dreq = 4'b0000; swReq = 4'b0000; mask = 4'b0000;
    ctrlDis = 1'b0; rotating = 1'b0; dreqLow = 1'b0; dackLow = 1'b0;
    hlda = 1'b0; xferDone = 1'b0;
    dreq3 = 3'b000; hlda3 = 1'b0; xferDone3 = 1'b0;
    modelReset();
    #2;
    checkOutput();
    tick();
    rst = 1'b0;
    tick();

    // Fixed priority, active-high: DREQ=1010 gives HRQ after 2 clocks, grant ch1.
    dreq = 4'b1010;
    tick();
    expectEq("t1_hrq_plus1", 32'(hrq), 32'd0);
    tick();
    expectEq("t1_hrq_plus2", 32'(hrq), 32'd1);
    expectEq("t1_grant", 32'(grantCh), 32'd1);
    serve(4'b0010);
    dreq = 4'b0000;
    tick();
    tick();

    // Rotating priority: ch1 then wrap to ch0, then ch1.
    rotating = 1'b1;
    dreq = 4'b0010;
    tick();
    tick();
    expectEq("t2_first", 32'(grantCh), 32'd1);
    serve(4'b0010);
    dreq = 4'b0011;
    tick();
    tick();
    expectEq("t2_wrap_ch0", 32'(grantCh), 32'd0);
    serve(4'b0001);
    tick();
    tick();
    expectEq("t2_then_ch1", 32'(grantCh), 32'd1);
    serve(4'b0010);
    dreq = 4'b0000;
    tick();
    tick();

    // Active-low DREQ and DACK.
    rotating = 1'b0;
    dreqLow = 1'b1;
    dackLow = 1'b1;
    dreq = 4'b1110;
    #1;
    expectEq("t3_dack_idle", 32'(dack), 32'hF);
    tick();
    tick();
    expectEq("t3_grant", 32'(grantCh), 32'd0);
    serve(4'b1110);
    dreq = 4'b1111;
    tick();
    tick();
    expectEq("t3_dack_after", 32'(dack), 32'hF);
    dreqLow = 1'b0;
    dackLow = 1'b0;
    dreq = 4'b0000;
    tick();

    // Masked software request is ignored until the mask clears.
    mask = 4'b0001;
    swReq = 4'b0001;
    tick();
    tick();
    tick();
    expectEq("t4_masked", 32'(hrq), 32'd0);
    mask = 4'b0000;
    tick();
    expectEq("t4_unmask_plus1", 32'(hrq), 32'd0);
    tick();
    expectEq("t4_unmask_plus2", 32'(hrq), 32'd1);
    expectEq("t4_grant", 32'(grantCh), 32'd0);
    serve(4'b0001);
    swReq = 4'b0000;
    tick();
    tick();

    // Winner drops in WAIT_HLDA, then HLDA abort in SERVICE leaves ptr alone.
    dreq = 4'b0100;
    tick();
    tick();
    expectEq("t5_grant2", 32'(grantCh), 32'd2);
    dreq = 4'b0000;
    tick();
    tick();
    expectEq("t5_drop_hrq", 32'(hrq), 32'd0);
    rotating = 1'b1;
    dreq = 4'b0010;
    tick();
    tick();
    hlda = 1'b1;
    tick();
    expectEq("t5_service", 32'(grantValid), 32'd1);
    hlda = 1'b0;
    dreq = 4'b0110;
    tick();
    expectEq("t5_abort_dack", 32'(dack), 32'h0);
    tick();
    expectEq("t5_ptr_kept", 32'(grantCh), 32'd1);
    dreq = 4'b0000;
    tick();
    tick();

    // Asynchronous reset in the middle of SERVICE.
    dreq = 4'b0001;
    tick();
    tick();
    hlda = 1'b1;
    tick();
    expectEq("t6_in_service", 32'(grantValid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    expectEq("t6_rst_hrq", 32'(hrq), 32'd0);
    expectEq("t6_rst_dack", 32'(dack), 32'h0);
    expectEq("t6_rst_valid", 32'(grantValid), 32'd0);
    modelReset();
    dreq = 4'b0000;
    hlda = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Three-channel unit: ch1 -> ptr 2 -> ch2 -> ptr wraps to 0 -> ch0.
    dreq3 = 3'b010;
    tick();
    tick();
    expectEq("nch3_hrq", 32'(hrq3), 32'd1);
    expectEq("nch3_grant1", 32'(grantCh3), 32'd1);
    serve3(3'b010, 3'b101);
    tick();
    expectEq("nch3_grant2", 32'(grantCh3), 32'd2);
    serve3(3'b100, 3'b011);
    tick();
    expectEq("nch3_wrap_ch0", 32'(grantCh3), 32'd0);
    dreq3 = 3'b000;
    tick();
    tick();
    expectEq("nch3_idle", 32'(hrq3), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
